// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage feeding decode / immediate generation.
// Owns the fetch PC, issues one word request at a time to instruction memory,
// buffers the returned word until decode takes it, and handles redirects from
// execute, including squashing a response that is already in flight.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   imem_req_*        request channel (valid/ready, address = internal pc)
//   imem_resp_*       response channel (single-cycle valid pulse, data, fault)
//   out_*             instruction handed to decode (valid/ready, word, pc, fault)
//   redirect_*        new fetch PC from execute (branch/jump/trap)
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned XLEN = 32;

  // BOOT: idle cycle after reset; REQ: issuing; WAIT: response pending;
  // DROP: pending response belongs to a squashed fetch; HOLD: word buffered.
  localparam logic [2:0] S_BOOT = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DROP = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  logic [2:0]      state;
  logic [2:0]      state_nx;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_nx;
  logic [XLEN-1:0] inst_nx;
  logic [XLEN-1:0] opc_nx;
  logic            fault_nx;
  logic            pc_aligned;
  logic            req_hs;
  logic            out_hs;

  assign pc_aligned     = (pc[1:0] == 2'b00);
  assign imem_req_valid = (state == S_REQ) && pc_aligned;
  assign imem_req_addr  = pc;
  // A redirect squashes the held word in the same cycle it arrives.
  assign out_valid      = (state == S_HOLD) && !redirect_valid;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign out_hs         = out_valid && out_ready;

  // Next-state, next-pc and output-buffer logic; redirect outranks everything.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    inst_nx  = out_inst;
    opc_nx   = out_pc;
    fault_nx = out_fault;
    case (state)
      S_BOOT: state_nx = S_REQ;
      S_REQ: begin
        if (redirect_valid) begin
          pc_nx    = redirect_pc;
          // An accepted request at the old pc must have its response dropped.
          state_nx = req_hs ? S_DROP : S_REQ;
        end else if (!pc_aligned) begin
          state_nx = S_HOLD;
          inst_nx  = NOP_INST;
          opc_nx   = pc;
          fault_nx = 1'b1;
        end else if (req_hs) begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_nx    = redirect_pc;
          state_nx = imem_resp_valid ? S_REQ : S_DROP;
        end else if (imem_resp_valid) begin
          state_nx = S_HOLD;
          inst_nx  = imem_resp_data;
          opc_nx   = pc;
          fault_nx = imem_resp_err;
        end
      end
      S_DROP: begin
        if (redirect_valid) pc_nx = redirect_pc;
        if (imem_resp_valid) state_nx = S_REQ;
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_nx    = redirect_pc;
          state_nx = S_REQ;
        end else if (out_hs) begin
          pc_nx    = pc + XLEN'(4);
          state_nx = S_REQ;
        end
      end
      default: state_nx = S_BOOT;
    endcase
  end

  // State, pc and output buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_BOOT;
      pc        <= RESET_PC;
      out_inst  <= '0;
      out_pc    <= '0;
      out_fault <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      out_inst  <= inst_nx;
      out_pc    <= opc_nx;
      out_fault <= fault_nx;
    end
  end

  // A response is only legal while a request is outstanding.
  resp_only_when_pending: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> ((state == S_WAIT) || (state == S_DROP)));

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage; sits directly upstream of decode and immediate generation. It feeds them the fetched instruction word and its PC.
- Owns the architectural fetch PC and issues one word request at a time to instruction memory over a valid/ready request channel plus a response channel.
- Holds the returned word in an output buffer until decode accepts it.
- Handles PC redirects from execute (branch/jump/trap), including squashing a response that is already in flight.

Parameters:
- RESET_PC, 32'h8000_0000, PC of the first fetch after reset.
- NOP_INST, 32'h0000_0013, word presented on out_inst when a fetch faults.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address, always equals the internal pc.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_resp_valid  in  1  response word valid, single-cycle pulse.
- imem_resp_data  in  32  instruction word.
- imem_resp_err  in  1  access fault for this response.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts the instruction.
- out_inst  out  32  instruction word, input to decode/ImmGen.
- out_pc  out  32  PC of out_inst.
- out_fault  out  1  instruction is a fetch fault (misaligned or access error).
- redirect_valid  in  1  redirect fetch to redirect_pc.
- redirect_pc  in  32  new fetch PC.

Behaviour:
- States: BOOT, REQ, WAIT, DROP, HOLD.
- Reset (async, rst=1): state=BOOT, pc=RESET_PC, out_inst=0, out_pc=0, out_fault=0. Outputs imem_req_valid=0 and out_valid=0 while rst=1 and in BOOT.
- BOOT: one idle cycle after reset release, then REQ.
- imem_req_valid = (state==REQ) && (pc[1:0]==0). It is independent of redirect_valid.
- out_valid = (state==HOLD) && !redirect_valid. The decode handshake fires only when out_valid && out_ready.
- At most one outstanding request. The response for an accepted request arrives no earlier than the cycle after acceptance.
- REQ, pc misaligned: no request is issued. Next state is HOLD with out_inst=NOP_INST, out_pc=pc, out_fault=1.
- REQ, handshake (req_valid && req_ready): go to WAIT.
- REQ, redirect_valid without handshake: pc<=redirect_pc, stay in REQ. The address may change while valid; memory must not latch it without ready.
- REQ, redirect_valid and handshake in the same cycle: pc<=redirect_pc, go to DROP.
- WAIT, resp_valid and no redirect: out_inst<=resp_data, out_pc<=pc, out_fault<=resp_err, go to HOLD.
- WAIT, redirect_valid and no resp_valid: pc<=redirect_pc, go to DROP.
- WAIT, redirect_valid and resp_valid in the same cycle: discard the response, pc<=redirect_pc, go to REQ.
- DROP: the next resp_valid is discarded, then go to REQ. A redirect in DROP updates pc and keeps state DROP, unless resp_valid arrives in the same cycle; then pc updates and the next state is REQ.
- HOLD, out handshake and no redirect: pc<=pc+4 (32-bit wraparound, 32'hFFFF_FFFC+4=0), go to REQ. There is no bubble beyond the REQ cycle. Back-to-back throughput is one instruction per 3 cycles minimum with 1-cycle memory.
- HOLD, redirect_valid: the held instruction is squashed and out_valid is forced to 0 that cycle. pc<=redirect_pc, go to REQ. out_ready is ignored.
- HOLD, no handshake: out_inst, out_pc and out_fault stay stable.
- Priority: rst > redirect_valid > response/handshake.
- Responses arriving in BOOT, REQ or HOLD are protocol violations. They are ignored, and a simulation-only assertion flags them.
- Reset asserted mid-transaction returns to BOOT immediately. A late response after reset release falls in BOOT/REQ and is ignored, so the memory must also be reset.

Test Plan:
- Reset release with 1-cycle-latency memory, out_ready=1 → first request at addr 0x8000_0000 in cycle 2. out_valid with out_pc=0x8000_0000, then 0x8000_0004, each carrying the memory word.
- out_ready=0 for 5 cycles during HOLD → out_inst and out_pc stay stable, no new imem request, pc advances only after the accepting cycle.
- Redirect to 0x8000_0100 one cycle after a request is accepted (WAIT) with a 3-cycle response → the stale response is discarded, out_valid never asserts for it, the next request address is 0x8000_0100.
- Redirect coincident with resp_valid in WAIT → no out_valid for that word. The next cycle is REQ with addr = redirect_pc.
- Redirect to 0x8000_0102 → no imem request. out_valid=1, out_fault=1, out_inst=0x0000_0013, out_pc=0x8000_0102.
- imem_resp_err=1 on the fetch at 0x8000_0008 → out_fault=1 with out_pc=0x8000_0008. After acceptance the next fetch is 0x8000_000C.
